// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / next-PC fetch stage.
// Imported by pc_next_sel and pc_fetch_unit.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = ~32'h3;

    function automatic logic low_bits_set(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: branch > jump > stall > sequential.
// Redirect targets are word-aligned and flagged when misaligned.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] MASK = ~(ADDR_W'(~ALIGN_MASK));
    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    logic [ADDR_W-1:0] target;

    always_comb begin
        target     = pcsrc ? branch_target : jump_target;
        redirect   = pcsrc | jump;
        misaligned = 1'b0;
        next_pc    = pc + INCR;
        if (redirect) begin
            next_pc    = target & MASK;
            misaligned = low_bits_set(target[1:0]);
        end else if (stall) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and IF/ID flush timer.
// Redirects win over stalls; flush length is FLUSH_CYCLES.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [ADDR_W-1:0] PC_Plus4,
    output logic              Flush_IFID,
    output logic              Misaligned_Err,
    output logic [1:0]        State_Out
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              misaligned;
    logic              err;
    logic [2:0]        flush_cnt;
    state_t            state;

    pc_next_sel #(
        .ADDR_W(ADDR_W)
    ) u_sel (
        .pc            (pc),
        .pcsrc         (PCSrc),
        .branch_target (BranchTarget),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .stall         (Stall),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc        <= RESET_PC;
            err       <= 1'b0;
            flush_cnt <= '0;
            state     <= RUN;
        end else begin
            pc  <= next_pc;
            err <= err | misaligned;
            if (redirect)
                flush_cnt <= FLUSH_LOAD;
            else if (flush_cnt != 3'd0)
                flush_cnt <= flush_cnt - 3'd1;
            // Next state depends only on inputs, so 2'd3 falls back to RUN.
            if (redirect)
                state <= REDIRECT;
            else if (Stall)
                state <= STALL;
            else
                state <= RUN;
        end
    end

    assign PC_Out         = pc;
    assign PC_Plus4       = pc + ADDR_W'(PC_INCR);
    assign Flush_IFID     = flush_cnt != 3'd0;
    assign Misaligned_Err = err;
    assign State_Out      = state;

endmodule
